// File: rtl/button_capture.sv
`default_nettype none
// ============================================================================
// button_capture : synchronised, debounced buttons with sticky W1C RISE/FALL
//                  capture on a 16-byte bus window.
// Optional IRQEN register / irq_out enabled by macro BUTTON_CAPTURE_IRQ_EN.
// Revision: 1.0
// ============================================================================
module button_capture #(
  parameter int BUTTONCOUNT     = 4,
  parameter int DEBOUNCE_CYCLES = 36000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [BUTTONCOUNT-1:0] buttons_in,
  input  logic [31:0]            address_in,
  input  logic                   sel_in,
  input  logic                   read_in,
  output logic [31:0]            read_value_out,
  input  logic [3:0]             write_mask_in,
  input  logic [31:0]            write_value_in,
  output logic                   ready_out,
  output logic                   irq_out
);

  localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_TERMINAL = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [BUTTONCOUNT-1:0] r_s1, r_s2, r_stable, r_rise, r_fall;
  logic [c_CNT_W-1:0]     r_cnt [BUTTONCOUNT];
  logic [BUTTONCOUNT-1:0] w_accept, w_rise_set, w_fall_set, w_rise_clr, w_fall_clr;
  logic [31:0]            w_irqen_rd;
  logic [1:0]             w_reg;
  logic                   w_wr_lo;
  logic                   w_unused;

  assign w_reg    = address_in[3:2];
  assign w_wr_lo  = sel_in & write_mask_in[0];
  assign w_unused = ^{read_in, address_in, write_mask_in, write_value_in};

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < BUTTONCOUNT; i++)
      w_accept[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == c_TERMINAL);
  end

  assign w_rise_set = w_accept & r_s2;
  assign w_fall_set = w_accept & ~r_s2;
  assign w_rise_clr = (w_wr_lo && w_reg == 2'd1) ? write_value_in[BUTTONCOUNT-1:0] : '0;
  assign w_fall_clr = (w_wr_lo && w_reg == 2'd2) ? write_value_in[BUTTONCOUNT-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_stable <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      for (int i = 0; i < BUTTONCOUNT; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= buttons_in;
      r_s2 <= r_s1;
      // Count only while the synchronised level disagrees; any bounce restarts.
      for (int i = 0; i < BUTTONCOUNT; i++) begin
        if (r_s2[i] == r_stable[i] || w_accept[i]) r_cnt[i] <= '0;
        else                                       r_cnt[i] <= r_cnt[i] + 1'b1;
      end
      r_stable <= (r_stable & ~w_accept) | (r_s2 & w_accept);
      // A new event outranks a simultaneous firmware clear.
      r_rise   <= (r_rise & ~w_rise_clr) | w_rise_set;
      r_fall   <= (r_fall & ~w_fall_clr) | w_fall_set;
    end
  end

`ifdef BUTTON_CAPTURE_IRQ_EN
  logic [BUTTONCOUNT-1:0] r_irqen_rise, r_irqen_fall;
  logic                   r_irq;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irqen_rise <= '0;
      r_irqen_fall <= '0;
      r_irq        <= 1'b0;
    end else begin
      if (sel_in && w_reg == 2'd3) begin
        if (write_mask_in[0]) r_irqen_rise <= write_value_in[BUTTONCOUNT-1:0];
        if (write_mask_in[1]) r_irqen_fall <= write_value_in[8 +: BUTTONCOUNT];
      end
      r_irq <= |((r_rise & r_irqen_rise) | (r_fall & r_irqen_fall));
    end
  end

  assign irq_out    = r_irq;
  assign w_irqen_rd = 32'(r_irqen_rise) | (32'(r_irqen_fall) << 8);
`else
  assign irq_out    = 1'b0;
  assign w_irqen_rd = '0;
`endif

  assign ready_out = sel_in;

  // Deselected peripherals drive 0 so the bus can OR all read values together.
  always_comb begin
    read_value_out = '0;
    if (sel_in) begin
      case (w_reg)
        2'd0:    read_value_out = 32'(r_stable);
        2'd1:    read_value_out = 32'(r_rise);
        2'd2:    read_value_out = 32'(r_fall);
        default: read_value_out = w_irqen_rd;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_capture.sv
`default_nettype none
// Randomised scoreboard bench for button_capture: window-based debounce model,
// expected bus read data queued at issue time and checked by a monitor.
module tb_button_capture;

  localparam int c_BC = 4;
  localparam int c_DC = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  buttons_in = '0;
  logic [31:0] address_in = '0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = '0;
  logic [31:0] read_value_out;
  logic        ready_out;
  logic        irq_out;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [3:0]  hist[$];
  logic [3:0]  m_stable = '0, m_rise = '0, m_fall = '0, m_ien_r = '0, m_ien_f = '0;
  logic        m_irq = 1'b0;
  logic [3:0]  pr, pf, cr, cf;
  logic        irq_nx, all_other, smp;
  int          n, n0;
  logic [31:0] exp_ien;

  button_capture #(.BUTTONCOUNT(c_BC), .DEBOUNCE_CYCLES(c_DC)) dut (
    .clk(clk), .reset(reset), .buttons_in(buttons_in), .address_in(address_in),
    .sel_in(sel_in), .read_in(read_in), .read_value_out(read_value_out),
    .write_mask_in(write_mask_in), .write_value_in(write_value_in),
    .ready_out(ready_out), .irq_out(irq_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_stable};
      2'd1:    return {28'd0, m_rise};
      2'd2:    return {28'd0, m_fall};
      default: return {20'd0, m_ien_f, 4'd0, m_ien_r};
    endcase
  endfunction

  // Reference: a level is accepted once DC consecutive samples, ending two
  // edges ago, all oppose the current debounced level.
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      hist.delete();
      m_stable = '0; m_rise = '0; m_fall = '0; m_ien_r = '0; m_ien_f = '0; m_irq = 1'b0;
    end else begin
      irq_nx = 1'b0;
`ifdef BUTTON_CAPTURE_IRQ_EN
      irq_nx = |((m_rise & m_ien_r) | (m_fall & m_ien_f));
`endif
      hist.push_back(buttons_in);
      n  = hist.size() - 1;
      pr = '0; pf = '0;
      for (int i = 0; i < c_BC; i++) begin
        all_other = 1'b1;
        for (int j = n - c_DC - 1; j <= n - 2; j++) begin
          if (j >= 0) smp = hist[j][i];
          else        smp = 1'b0;
          if (smp == m_stable[i]) all_other = 1'b0;
        end
        if (all_other) begin
          if (m_stable[i]) pf[i] = 1'b1;
          else             pr[i] = 1'b1;
          m_stable[i] = ~m_stable[i];
        end
      end
      cr = '0; cf = '0;
      if (sel_in && write_mask_in[0] && address_in[3:2] == 2'd1) cr = write_value_in[3:0];
      if (sel_in && write_mask_in[0] && address_in[3:2] == 2'd2) cf = write_value_in[3:0];
`ifdef BUTTON_CAPTURE_IRQ_EN
      if (sel_in && address_in[3:2] == 2'd3) begin
        if (write_mask_in[0]) m_ien_r = write_value_in[3:0];
        if (write_mask_in[1]) m_ien_f = write_value_in[11:8];
      end
`endif
      m_rise = (m_rise & ~cr) | pr;
      m_fall = (m_fall & ~cf) | pf;
      m_irq  = irq_nx;
    end
  end

  // Monitor: pops an expected read value whenever the DUT presents ready.
  initial forever begin
    @(negedge clk);
    #1;
    check("ready", {31'd0, ready_out}, {31'd0, sel_in});
    if (ready_out) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL read_unexpected: got %h expected no transfer", read_value_out);
      end else begin
        check("read_data", read_value_out, exp_q.pop_front());
      end
    end else begin
      check("read_idle", read_value_out, 32'd0);
    end
    check("irq", {31'd0, irq_out}, {31'd0, m_irq});
  end

  // One bus cycle starting at the current negedge.
  task automatic bus(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] val,
                     input logic use_exp, input logic [31:0] exp);
    sel_in = 1'b1; read_in = (mask == 4'd0); address_in = addr;
    write_mask_in = mask; write_value_in = val;
    exp_q.push_back(use_exp ? exp : model_read(addr[3:2]));
    @(negedge clk);
    sel_in = 1'b0; read_in = 1'b0; write_mask_in = '0;
  endtask

  task automatic rd_exp(input logic [31:0] addr, input logic [31:0] exp);
    bus(addr, 4'd0, 32'd0, 1'b1, exp);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] val);
    bus(addr, mask, val, 1'b0, 32'd0);
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic wait_size(input int sz);
    while (hist.size() < sz) @(negedge clk);
  endtask

  task automatic random_phase(input int cycles);
    repeat (cycles) begin
      for (int i = 0; i < c_BC; i++)
        if ($urandom_range(0, 19) == 0) buttons_in[i] = ~buttons_in[i];
      if ($urandom_range(0, 2) == 0) bus($urandom(), 4'($urandom_range(0, 15)), $urandom(), 1'b0, 32'd0);
      else @(negedge clk);
    end
  endtask

  initial begin
    buttons_in = 4'b0101;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    rd_exp(32'h0, 32'h0); rd_exp(32'h4, 32'h0); rd_exp(32'h8, 32'h0); rd_exp(32'hC, 32'h0);
    wait_size(17);
    rd_exp(32'h0, 32'h0);
    rd_exp(32'h0, 32'h5);
    rd_exp(32'h4, 32'h5);
    rd_exp(32'h8, 32'h0);

    // Simultaneous terminal-count set and W1C on RISE[0].
    buttons_in[0] = 1'b0;
    idle(c_DC + 4);
    rd_exp(32'h8, 32'h1);
    buttons_in[0] = 1'b1;
    n0 = hist.size();
    wait_size(n0 + c_DC + 1);
    wr(32'h4, 4'b0001, 32'h1);
    rd_exp(32'h4, 32'h5);
    wr(32'h4, 4'b0000, 32'hF);
    rd_exp(32'h4, 32'h5);
    wr(32'h4, 4'b0001, 32'h1);
    rd_exp(32'h4, 32'h4);

    // Button 1 bouncing faster than the debounce window, then held.
    for (int t = 0; t < 100; t++) begin
      if (t % 10 == 0) buttons_in[1] = ~buttons_in[1];
      if (t % 10 == 5)      rd_exp(32'h0, 32'h5);
      else if (t % 10 == 7) rd_exp(32'h4, 32'h4);
      else                  @(negedge clk);
    end
    buttons_in[1] = 1'b1;
    n0 = hist.size();
    wait_size(n0 + c_DC + 1);
    rd_exp(32'h0, 32'h5);
    rd_exp(32'h0, 32'h7);
    rd_exp(32'h4, 32'h6);

    // Fall interrupt path.
    wr(32'h8, 4'b0001, 32'hF);
    wr(32'hC, 4'b0011, 32'h0100);
    buttons_in[0] = 1'b0;
    idle(c_DC + 4);
    rd_exp(32'h8, 32'h1);
    wr(32'h8, 4'b0001, 32'h1);
    idle(2);
    wr(32'hC, 4'b0011, 32'hFFFF);
`ifdef BUTTON_CAPTURE_IRQ_EN
    exp_ien = 32'h0F0F;
`else
    exp_ien = 32'h0;
`endif
    rd_exp(32'hC, exp_ien);

    random_phase(3000);

    // Asynchronous reset in the middle of activity.
    #2 reset = 1'b0;
    idle(3);
    reset = 1'b1;
    rd_exp(32'h0, 32'h0); rd_exp(32'h4, 32'h0); rd_exp(32'h8, 32'h0); rd_exp(32'hC, 32'h0);

    random_phase(1500);
    idle(3);
    check("queue_drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
